// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the receiver.
//   uart_tx_state_t : transmitter FSM state encoding
//   UART_DATA_BITS  : data bits per frame
//   UART_STOP_BITS  : stop bits per frame
//   uart_parity()   : even parity bit of one data byte
package uart_pkg;

   localparam int UART_DATA_BITS = 8;
   localparam int UART_STOP_BITS = 2;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_tx_state_t;

   // Returns the bit that makes the total count of ones (data + parity) even.
   function automatic logic uart_parity(input logic [UART_DATA_BITS-1:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/uart_tx_if.sv
// System-side byte write port of the UART transmitter.
//   wdata  : byte to transmit
//   wvalid : wdata is valid
//   wready : transmitter can accept a byte (transfer when wvalid && wready)
// master = byte producer, slave = uart_tx.
interface uart_tx_if;
   import uart_pkg::*;

   logic [UART_DATA_BITS-1:0] wdata;
   logic                      wvalid;
   logic                      wready;

   modport master (output wdata, output wvalid, input  wready);
   modport slave  (input  wdata, input  wvalid, output wready);

endinterface

// File: rtl/fifo.sv
// Synchronous show-ahead FIFO; rd_data always presents the head entry.
//   clk, rst   : clock, asynchronous active-high reset (empties the FIFO)
//   wr_en      : enqueue wr_data (ignored while full)
//   wr_data    : entry to enqueue
//   rd_en      : dequeue head entry (ignored while empty)
//   rd_data    : current head entry
//   full/empty : occupancy flags
module fifo #(
   parameter int data_size   = 8,
   parameter int buffer_size = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [data_size-1:0] wr_data,
   input  logic                 rd_en,
   output logic [data_size-1:0] rd_data,
   output logic                 full,
   output logic                 empty
);

   localparam int AW = (buffer_size > 1) ? $clog2(buffer_size) : 1;
   localparam int CW = $clog2(buffer_size + 1);

   logic [data_size-1:0] mem [buffer_size];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [CW-1:0]        count;
   logic                 do_wr;
   logic                 do_rd;

   // Pointers wrap explicitly so non-power-of-two depths work.
   function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
      return (p == AW'(buffer_size - 1)) ? '0 : p + 1'b1;
   endfunction

   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign full    = (count == CW'(buffer_size));
   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= ptr_next(wr_ptr);
         end
         if (do_rd) begin
            rd_ptr <= ptr_next(rd_ptr);
         end
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: buffers bytes in a FIFO and shifts each out as a 12-bit
// frame (start, 8 data LSB first, even parity, 2 stop), CLK_DIV clocks/bit.
//   clk, rst : clock, asynchronous active-high reset
//   wif      : byte write port (slave side)
//   tx       : registered serial output, idles high
//   cts_n    : far end ready when low, sampled only between frames
//   rts_n    : low while bytes are queued or a frame is in progress
//   busy     : high while a frame is being shifted out
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_DIV    = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   uart_tx_if.slave   wif,
   output logic       tx,
   input  logic       cts_n,
   output logic       rts_n,
   output logic       busy
);

   localparam int BW = $clog2(CLK_DIV);

   uart_tx_state_t            state;
   uart_tx_state_t            next_state;
   logic [BW-1:0]             baud_q;
   logic [BW-1:0]             baud_d;
   logic [2:0]                bit_q;
   logic [2:0]                bit_d;
   logic [UART_DATA_BITS-1:0] shift_q;
   logic [UART_DATA_BITS-1:0] shift_d;
   logic                      par_q;
   logic                      par_d;
   logic                      tx_d;
   logic                      bit_end;
   logic                      deq;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic [UART_DATA_BITS-1:0] fifo_rdata;

   fifo #(
      .data_size   (UART_DATA_BITS),
      .buffer_size (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wif.wvalid),
      .wr_data (wif.wdata),
      .rd_en   (deq),
      .rd_data (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign wif.wready = !fifo_full;
   assign busy       = (state != IDLE);
   assign rts_n      = !(!fifo_empty || busy);
   assign bit_end    = (baud_q == BW'(CLK_DIV - 1));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; the head byte is dequeued in the same cycle the
   // frame is launched.
   always_comb begin
      next_state = state;
      deq        = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty && !cts_n) begin
               next_state = START;
               deq        = 1'b1;
            end
         end
         START: begin
            if (bit_end) next_state = DATA;
         end
         DATA: begin
            if (bit_end && bit_q == 3'(UART_DATA_BITS - 1)) next_state = PARITY;
         end
         PARITY: begin
            if (bit_end) next_state = STOP;
         end
         STOP: begin
            if (bit_end && bit_q == 3'(UART_STOP_BITS - 1)) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Output/datapath next values. tx is registered, so its next level is
   // derived from the state and shift contents that take effect at the edge.
   always_comb begin
      baud_d  = (state == IDLE || bit_end) ? '0 : baud_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;

      if (deq) begin
         shift_d = fifo_rdata;
         par_d   = uart_parity(fifo_rdata);
      end
      if (state == DATA && bit_end) begin
         shift_d = shift_q >> 1;
         bit_d   = bit_q + 1'b1;
      end
      // The bit counter is reused to count stop bits.
      if (state == STOP && bit_end) begin
         bit_d = (bit_q == 3'(UART_STOP_BITS - 1)) ? '0 : bit_q + 1'b1;
      end

      case (next_state)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         PARITY:  tx_d = par_d;
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx      <= 1'b1;
      end else begin
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx      <= tx_d;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx (CLK_DIV = 4, FIFO_DEPTH = 8).
// A frame-level model predicts tx/busy/rts_n/wready every cycle; directed
// tests add hand-computed literal expectations.
module tb_uart_tx;

   localparam int CLK_DIV = 4;
   localparam int DEPTH   = 8;
   localparam int FCYC    = 12 * CLK_DIV;

   logic clk = 1'b0;
   logic rst;
   logic cts_n;
   logic tx;
   logic rts_n;
   logic busy;

   uart_tx_if wif ();

   uart_tx #(
      .CLK_DIV    (CLK_DIV),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .wif   (wif.slave),
      .tx    (tx),
      .cts_n (cts_n),
      .rts_n (rts_n),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   bit chk_en      = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Line image of one frame, index = bit period in time order.
   function automatic logic [11:0] frame_of(input logic [7:0] b);
      logic [11:0] f;
      int ones;
      ones = 0;
      f    = '0;
      for (int i = 0; i < 8; i++) begin
         f[i+1] = b[i];
         if (b[i]) ones++;
      end
      f[9]  = (ones % 2 == 1);
      f[10] = 1'b1;
      f[11] = 1'b1;
      return f;
   endfunction

   // Model: queue of pending bytes plus the frame being sent and its cycle.
   logic [7:0]  mq [$];
   bit          in_frame = 1'b0;
   int          ft       = 0;
   logic [11:0] mframe   = '1;

   // Compare, then advance the model with the inputs the DUT will sample at
   // the next rising edge (inputs only change just after rising edges).
   always @(negedge clk) begin
      bit acc;
      bit launch;
      if (rst) begin
         mq.delete();
         in_frame = 1'b0;
         ft       = 0;
      end
      if (chk_en) begin
         check("tx",     tx,     in_frame ? mframe[ft / CLK_DIV] : 1'b1);
         check("busy",   busy,   in_frame);
         check("rts_n",  rts_n,  !(mq.size() != 0 || in_frame));
         check("wready", wif.wready, mq.size() < DEPTH);
      end
      if (!rst) begin
         acc    = wif.wvalid && (mq.size() < DEPTH);
         launch = !in_frame && (mq.size() != 0) && !cts_n;
         if (in_frame) begin
            ft++;
            if (ft == FCYC) in_frame = 1'b0;
         end
         if (launch) begin
            mframe   = frame_of(mq.pop_front());
            in_frame = 1'b1;
            ft       = 0;
         end
         if (acc) mq.push_back(wif.wdata);
      end
   end

   task automatic write_byte(input logic [7:0] b, output logic acc);
      @(posedge clk);
      #1 wif.wdata = b;
      wif.wvalid = 1'b1;
      @(negedge clk);
      acc = wif.wready;
      @(posedge clk);
      #1 wif.wvalid = 1'b0;
   endtask

   // Counts negedges until busy is seen (bounded).
   task automatic wait_busy(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!busy && n < 400);
      check("frame_started", busy, 1'b1);
   endtask

   // Called at the negedge of the first frame cycle.
   task automatic capture(output logic [11:0] bits, output bit steady,
                          output int bcnt, output logic idle_b);
      steady = 1'b1;
      bcnt   = 0;
      bits   = '0;
      for (int k = 0; k < FCYC; k++) begin
         if (k != 0) @(negedge clk);
         if (k % CLK_DIV == 0) bits[k / CLK_DIV] = tx;
         else if (tx !== bits[k / CLK_DIV]) steady = 1'b0;
         if (busy) bcnt++;
      end
      @(negedge clk);
      idle_b = busy;
   endtask

   task automatic expect_frame(input logic [7:0] b, input int lat, input string tag,
                               output logic [11:0] bits);
      int n;
      bit steady;
      int bcnt;
      logic idle_b;
      wait_busy(n);
      check({tag, "_latency"}, n, lat);
      capture(bits, steady, bcnt, idle_b);
      check({tag, "_data"}, bits[8:1], b);
      check({tag, "_line"}, bits, frame_of(b));
      check({tag, "_steady"}, steady, 1'b1);
      check({tag, "_busy_cycles"}, bcnt, FCYC);
      check({tag, "_idle_gap"}, idle_b, 1'b0);
   endtask

   initial begin
      logic [11:0] bits;
      logic        acc;
      int          n;
      int          nacc;
      int          bcnt;

      rst        = 1'b1;
      cts_n      = 1'b0;
      wif.wvalid = 1'b0;
      wif.wdata  = '0;
      repeat (3) @(posedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_tx", tx, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_rts_n", rts_n, 1'b1);
      check("rst_wready", wif.wready, 1'b1);
      @(posedge clk);
      #1 rst = 1'b0;

      // Model pin: 0xA5 line = 0 | 1,0,1,0,0,1,0,1 | 0 | 1,1
      check("model_a5", frame_of(8'hA5), 12'hD4A);

      // 0xA5: latency, line shape, busy length
      write_byte(8'hA5, acc);
      @(negedge clk);
      check("a5_rts_n_w1", rts_n, 1'b0);
      check("a5_tx_w1", tx, 1'b1);
      wait_busy(n);
      check("a5_latency", n, 1);
      begin
         bit steady;
         logic idle_b;
         capture(bits, steady, bcnt, idle_b);
         check("a5_line_literal", bits, 12'hD4A);
         check("a5_steady", steady, 1'b1);
         check("a5_busy_cycles", bcnt, 48);
         check("a5_idle_after", idle_b, 1'b0);
      end

      // Parity corner cases
      write_byte(8'h07, acc);
      expect_frame(8'h07, 2, "b07", bits);
      check("b07_parity", bits[9], 1'b1);
      write_byte(8'h00, acc);
      expect_frame(8'h00, 2, "b00", bits);
      check("b00_parity", bits[9], 1'b0);
      check("b00_databits", bits[8:1], 8'h00);

      // cts_n holds off three queued frames, then they go back-to-back
      cts_n = 1'b1;
      write_byte(8'h11, acc);
      write_byte(8'h22, acc);
      write_byte(8'h33, acc);
      repeat (20) @(negedge clk);
      check("hold_tx", tx, 1'b1);
      check("hold_rts_n", rts_n, 1'b0);
      check("hold_busy", busy, 1'b0);
      @(posedge clk);
      #1 cts_n = 1'b0;
      expect_frame(8'h11, 2, "q11", bits);
      expect_frame(8'h22, 1, "q22", bits);
      expect_frame(8'h33, 1, "q33", bits);

      // Fill beyond depth: 9th write dropped, exactly 8 frames
      cts_n = 1'b1;
      nacc  = 0;
      for (int i = 0; i < 9; i++) begin
         write_byte(8'h40 + 8'(i), acc);
         if (acc) nacc++;
         if (i == 8) check("ninth_wready", acc, 1'b0);
      end
      check("accepted_count", nacc, 8);
      @(posedge clk);
      #1 cts_n = 1'b0;
      for (int i = 0; i < 8; i++) begin
         expect_frame(8'h40 + 8'(i), (i == 0) ? 2 : 1, "full", bits);
      end
      bcnt = 0;
      repeat (60) begin
         @(negedge clk);
         if (busy) bcnt++;
      end
      check("no_ninth_frame", bcnt, 0);
      check("drained_rts_n", rts_n, 1'b1);

      // cts_n raised during data bit 3 of the first of two queued frames
      cts_n = 1'b1;
      write_byte(8'h5A, acc);
      write_byte(8'hC3, acc);
      @(posedge clk);
      #1 cts_n = 1'b0;
      wait_busy(n);
      check("cts_first_latency", n, 2);
      fork
         begin
            repeat (4 * CLK_DIV) @(posedge clk);
            #1 cts_n = 1'b1;
         end
         begin
            bit steady;
            logic idle_b;
            capture(bits, steady, bcnt, idle_b);
            check("cts_first_line", bits, frame_of(8'h5A));
            check("cts_first_steady", steady, 1'b1);
            check("cts_first_busy", bcnt, FCYC);
         end
      join
      repeat (30) @(negedge clk);
      check("cts_withheld_busy", busy, 1'b0);
      check("cts_withheld_tx", tx, 1'b1);
      check("cts_withheld_rts_n", rts_n, 1'b0);
      @(posedge clk);
      #1 cts_n = 1'b0;
      expect_frame(8'hC3, 2, "cts_second", bits);

      // Reset during DATA with two bytes still queued
      cts_n = 1'b1;
      write_byte(8'h81, acc);
      write_byte(8'h82, acc);
      write_byte(8'h83, acc);
      @(posedge clk);
      #1 cts_n = 1'b0;
      wait_busy(n);
      repeat (2 * CLK_DIV) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("midrst_tx", tx, 1'b1);
      check("midrst_busy", busy, 1'b0);
      check("midrst_rts_n", rts_n, 1'b1);
      @(posedge clk);
      #1 rst = 1'b0;
      bcnt = 0;
      repeat (100) begin
         @(negedge clk);
         if (busy || !tx) bcnt++;
      end
      check("post_rst_no_frame", bcnt, 0);
      check("post_rst_wready", wif.wready, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
